// File: rtl/alu_arbiter_ctrl.sv
// Round-robin front end that shares one combinational ALU between two requesters.
// Operands are launched from registers and the result is returned with a valid/ready handshake.
module alu_arbiter_ctrl #(
    parameter int W  = 8,
    parameter int SW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic [W-1:0]  a0,
    input  logic [W-1:0]  b0,
    input  logic [SW-1:0] sel0,
    output logic          gnt0,
    input  logic          req1,
    input  logic [W-1:0]  a1,
    input  logic [W-1:0]  b1,
    input  logic [SW-1:0] sel1,
    output logic          gnt1,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    output logic [SW-1:0] alu_sel,
    input  logic [W-1:0]  alu_out,
    output logic          res_valid,
    output logic [W-1:0]  res_data,
    output logic          res_id,
    input  logic          res_ready,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    logic   last;
    logic   pend_id;
    logic   any_req;
    logic   winner;
    logic   launch;

    // On a tie the requester that did not win last time goes first.
    assign any_req = req0 | req1;
    assign winner  = (req0 && req1) ? ~last : req1;

    // A new operation starts from IDLE, or straight out of DONE when the result is taken.
    assign launch = any_req && ((state == IDLE) || (state == DONE && res_ready));

    assign busy = (state != IDLE);

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples pre-edge values, regardless of statement order in this block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= 1'b0;
            pend_id   <= 1'b0;
            last      <= 1'b1;
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;

            if (launch) begin
                gnt0    <= ~winner;
                gnt1    <= winner;
                alu_a   <= winner ? a1 : a0;
                alu_b   <= winner ? b1 : b0;
                alu_sel <= winner ? sel1 : sel0;
                pend_id <= winner;
                last    <= winner;
            end

            case (state)
                IDLE: begin
                    if (any_req) begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    res_data  <= alu_out;
                    res_id    <= pend_id;
                    res_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= any_req ? EXEC : IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
